// File: rtl/layer1_conv_ctrl.sv
// layer1_conv_ctrl: walks a valid 3x3 conv over a 3-channel map, accumulating the
// 8-filter MAC datapath sums per output pixel and handing pixels out over valid/ready.
module layer1_conv_ctrl #(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int WORDLENGTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    relu_en_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    in_rd_o,
    output logic [15:0]             in_addr_o,
    input  logic [3*WORDLENGTH-1:0] in_data_i,
    output logic [3*WORDLENGTH-1:0] input_channel_o,
    output logic [3:0]              weight_sel_o,
    input  logic [8*WORDLENGTH-1:0] sum_in_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [8*WORDLENGTH-1:0] out_data_o,
    output logic [15:0]             out_addr_o
);
    localparam int WL = WORDLENGTH;
    localparam logic [15:0] IW     = 16'(IMG_W);
    localparam logic [15:0] OW     = 16'(IMG_W - 2);
    localparam logic [15:0] LAST_X = 16'(IMG_W - 3);
    localparam logic [15:0] LAST_Y = 16'(IMG_H - 3);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, DONE} state_e;

    state_e               state_q, state_d;
    logic [15:0]          ox_q, ox_d, oy_q, oy_d;
    logic [3:0]           tap_q, tap_d;
    logic                 relu_q, relu_d;
    logic                 rd_dly_q;
    logic [3:0]           tap_dly_q;
    logic [7:0][WL-1:0]   acc_q, acc_d;

    always_comb begin
        state_d = state_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        tap_d   = tap_q;
        relu_d  = relu_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = FETCH;
                ox_d    = '0;
                oy_d    = '0;
                tap_d   = '0;
                relu_d  = relu_en_i;
            end
            FETCH: begin
                tap_d   = (tap_q == 4'd8) ? 4'd0 : tap_q + 4'd1;
                state_d = (tap_q == 4'd8) ? DRAIN : FETCH;
            end
            DRAIN: state_d = OUT;
            OUT: if (out_ready_i) begin
                if (ox_q == LAST_X && oy_q == LAST_Y) begin
                    state_d = DONE;
                end else begin
                    state_d = FETCH;
                    ox_d    = (ox_q == LAST_X) ? 16'd0 : ox_q + 16'd1;
                    oy_d    = (ox_q == LAST_X) ? oy_q + 16'd1 : oy_q;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ox_q      <= '0;
            oy_q      <= '0;
            tap_q     <= '0;
            relu_q    <= 1'b0;
            rd_dly_q  <= 1'b0;
            tap_dly_q <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            tap_q     <= tap_d;
            relu_q    <= relu_d;
            rd_dly_q  <= in_rd_o;
            tap_dly_q <= tap_q;
            acc_q     <= acc_d;
        end
    end

    // Data returns one cycle after the read, so accumulation follows the delayed tap.
    for (genvar g = 0; g < 8; g++) begin : g_ch
        logic [WL-1:0] a, b, sat;
        logic [WL:0]   s;
        assign a   = acc_q[g];
        assign b   = sum_in_i[g*WL +: WL];
        assign s   = {a[WL-1], a} + {b[WL-1], b};
        assign sat = (s[WL] != s[WL-1]) ? {s[WL], {(WL-1){~s[WL]}}} : s[WL-1:0];
        assign acc_d[g] = !rd_dly_q ? a : (tap_dly_q == 4'd0 ? b : sat);
        assign out_data_o[g*WL +: WL] = (relu_q && a[WL-1]) ? '0 : a;
    end

    assign busy_o          = state_q != IDLE;
    assign done_o          = state_q == DONE;
    assign in_rd_o         = state_q == FETCH;
    assign in_addr_o       = in_rd_o ? (oy_q + {12'd0, tap_q / 4'd3}) * IW + ox_q + {12'd0, tap_q % 4'd3} : 16'd0;
    assign weight_sel_o    = rd_dly_q ? tap_dly_q : 4'd0;
    assign out_valid_o     = state_q == OUT;
    assign out_addr_o      = oy_q * OW + ox_q;
    assign input_channel_o = in_data_i;
endmodule

// File: tb/tb_layer1_conv_ctrl.sv
// tb_layer1_conv_ctrl: vector table of full passes on a 4x4 map, scoreboarded output
// pixels, plus cycle-exact timing, backpressure and mid-pass reset sequences.
module tb_layer1_conv_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, relu_en = 1'b0, out_ready = 1'b1;
    logic         busy, done, in_rd, out_valid;
    logic [15:0]  in_addr, out_addr;
    logic [47:0]  in_data = '0, input_channel;
    logic [3:0]   weight_sel;
    logic [127:0] sum_in = '0, out_data;

    int chk_cnt = 0, pass_cnt = 0, npix = 0;
    logic [143:0] sb[$];

    typedef struct {
        logic [127:0] sum;
        bit           relu;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs[6];

    layer1_conv_ctrl #(.IMG_W(4), .IMG_H(4), .WORDLENGTH(16)) dut (
        .clk(clk), .rst(rst), .start_i(start), .relu_en_i(relu_en),
        .busy_o(busy), .done_o(done), .in_rd_o(in_rd), .in_addr_o(in_addr),
        .in_data_i(in_data), .input_channel_o(input_channel), .weight_sel_o(weight_sel),
        .sum_in_i(sum_in), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_addr_o(out_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Nine equal taps with per-step saturation land on clamp(9*v).
    function automatic logic [127:0] exp_of(input logic [127:0] s, input bit relu);
        logic [127:0] r;
        int v;
        for (int c = 0; c < 8; c++) begin
            v = 9 * int'($signed(s[c*16 +: 16]));
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
            if (relu && v < 0) v = 0;
            r[c*16 +: 16] = 16'(v);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            npix++;
            if (sb.size() == 0) check("sb_underflow", 200'(sb.size()), 200'd1);
            else check("pixel", {out_addr, out_data}, sb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pass(input logic [127:0] e);
        for (int p = 0; p < 4; p++) sb.push_back({16'(p), e});
    endtask

    task automatic run_pass(input vec_t v, input bit detail);
        int ndone = 0;
        sum_in = v.sum;
        relu_en = v.relu;
        npix = 0;
        push_pass(v.exp);
        start = 1'b1;
        for (int t = 1; t <= 47; t++) begin
            step();
            start = (t == 15);
            if (t == 20) relu_en = ~v.relu;
            @(negedge clk);
            if (done) ndone++;
            if (detail) begin
                int p, ph;
                logic [23:0] e;
                p = (t - 1) / 11;
                ph = (t - 1) % 11;
                e = '0;
                if (t <= 44) begin
                    e[0]    = (ph == 10);
                    e[4:1]  = (ph >= 1 && ph <= 9) ? 4'(ph - 1) : 4'd0;
                    e[20:5] = (ph < 9) ? 16'((p / 2 + ph / 3) * 4 + p % 2 + ph % 3) : 16'd0;
                    e[21]   = (ph < 9);
                end else if (t == 45) begin
                    e[22] = 1'b1;
                end
                e[23] = (t <= 45);
                check($sformatf("timing_t%0d", t), {busy, done, in_rd, in_addr, weight_sel, out_valid}, 200'(e));
            end
        end
        check("done_count", 200'(ndone), 200'd1);
        check("pixel_count", 200'(npix), 200'd4);
        check("sb_drained", 200'(sb.size()), 200'd0);
        relu_en = 1'b0;
    endtask

    initial begin
        logic [127:0] d0;
        bit seen;
        vecs[0] = '{{8{16'h0100}}, 1'b0, '0};
        vecs[1] = '{{{6{16'h0100}}, 16'h9000, 16'h7000}, 1'b0, '0};
        vecs[2] = '{{8{16'hFF00}}, 1'b1, '0};
        vecs[3] = '{{8{16'hFF00}}, 1'b0, '0};
        vecs[4] = '{{16'h0123, 16'hEFFF, 16'h0000, 16'h1000, 16'hF1C8, 16'h0E38, 16'hFFFF, 16'h0001}, 1'b1, '0};
        vecs[5] = '{vecs[4].sum, 1'b0, '0};
        for (int i = 0; i < 6; i++) vecs[i].exp = exp_of(vecs[i].sum, vecs[i].relu);

        @(negedge clk);
        check("reset_outputs", {busy, done, in_rd, in_addr, weight_sel, out_valid, out_data, out_addr}, 200'd0);
        step();
        rst = 1'b0;
        in_data = 48'h123456789ABC;
        #1;
        check("input_forward", 200'(input_channel), 200'(in_data));

        for (int i = 0; i < 6; i++) run_pass(vecs[i], i == 0);

        // Backpressure: hold pixel 0 for five cycles, then accept.
        sum_in = vecs[0].sum;
        out_ready = 1'b0;
        npix = 0;
        push_pass(vecs[0].exp);
        start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = out_valid;
            if (!seen) step();
        end
        check("bp_valid_seen", 200'(seen), 200'd1);
        d0 = out_data;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                step();
                @(negedge clk);
            end
            check($sformatf("bp_hold%0d", k), {out_valid, in_rd, out_data, out_addr}, {1'b1, 1'b0, d0, 16'd0});
        end
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("bp_fetch_after_accept", {in_rd, in_addr}, {1'b1, 16'd1});
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        check("bp_done_seen", 200'(seen), 200'd1);
        check("bp_pixel_count", 200'(npix), 200'd4);
        step();

        // Mid-pass reset during pixel 1 fetch aborts the pass.
        push_pass(vecs[0].exp);
        start = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            step();
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("rst_outputs", {busy, done, in_rd, in_addr, weight_sel, out_valid, out_data, out_addr}, 200'd0);
        sb.delete();
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seen |= out_valid | done;
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seen |= busy | out_valid | done;
            step();
        end
        check("rst_quiet", 200'(seen), 200'd0);
        run_pass(vecs[0], 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
